// File: rtl/md_sched_pkg.sv
// Shared multiply/divide encodings, latency defaults and scheduler FSM states.
package md_sched_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_mul_op(logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// Pipeline-control bundle between the hazard/decode logic and the MD scheduler.
interface md_sched_if;
  import md_sched_pkg::*;

  logic       req;
  logic [3:0] mdOp_E;
  logic       md_use_D;
  logic       stall_data;
  logic       start;
  logic       busy;
  logic       done;
  logic       stall;
  logic       pc_en;
  logic       FD_en;
  logic       DE_clr;
  logic       EM_en;

  modport master (
    output req, mdOp_E, md_use_D, stall_data,
    input  start, busy, done, stall, pc_en, FD_en, DE_clr, EM_en
  );

  modport slave (
    input  req, mdOp_E, md_use_D, stall_data,
    output start, busy, done, stall, pc_en, FD_en, DE_clr, EM_en
  );
endinterface

// File: rtl/md_sched_cnt.sv
// Loadable 4-bit down-counter; is_one_o marks the final busy cycle.
module md_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       is_one_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != 4'd0))
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign is_one_o = (cnt_q == 4'd1);

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: launches MDU ops, tracks their latency, stalls dependent MD instructions.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic     clk,
  input  logic     reset,
  md_sched_if.slave bus
);

  localparam logic [3:0] MULT_L = 4'(MULT_LAT);
  localparam logic [3:0] DIV_L  = 4'(DIV_LAT);

  md_state_e state_q, state_d;
  logic      is_mul, is_div;
  logic      start_w, busy_w, done_w, cnt_one, md_stall;

  assign is_mul = is_mul_op(bus.mdOp_E);
  assign is_div = is_div_op(bus.mdOp_E);

  // A faulting instruction (req) is flushed, so it must not launch.
  assign start_w = (is_mul || is_div) && !busy_w && !bus.req;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // req never leaves RUN: an in-flight operation always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_w) state_d = ST_RUN;
      ST_RUN:  if (cnt_one) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_w = 1'b0;
    done_w = 1'b0;
    if (state_q == ST_RUN) begin
      busy_w = 1'b1;
      done_w = cnt_one;
    end
  end

  md_cnt u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start_w),
    .load_val_i (is_mul ? MULT_L : DIV_L),
    .dec_i      (busy_w),
    .is_one_o   (cnt_one)
  );

  assign md_stall   = bus.md_use_D && (start_w || busy_w);

  assign bus.start  = start_w;
  assign bus.busy   = busy_w;
  assign bus.done   = done_w;
  assign bus.stall  = bus.stall_data || md_stall;
  assign bus.pc_en  = !bus.stall;
  assign bus.FD_en  = !bus.stall;
  assign bus.DE_clr = bus.stall;
  assign bus.EM_en  = 1'b1;

endmodule

// File: tb/tb_md_sched.sv
// Directed scoreboard bench for md_sched: driver queues expected outputs, monitor checks at negedge.
module tb_md_sched;
  import md_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_sched_if bus ();

  md_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Outputs packed as {start,busy,done,stall,pc_en,FD_en,DE_clr,EM_en}
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = {bus.start, bus.busy, bus.done, bus.stall,
             bus.pc_en, bus.FD_en, bus.DE_clr, bus.EM_en};
      n_chk++;
      if (act !== e.v)
        $display("FAIL %s act=%b exp=%b (start,busy,done,stall,pc_en,FD_en,DE_clr,EM_en)",
                 e.name, act, e.v);
      else
        n_pass++;
    end
  end

  task automatic step(input string nm, input bit rst, input bit rq, input logic [3:0] op,
                      input bit use_d, input bit sd,
                      input bit e_start, input bit e_busy, input bit e_done, input bit e_stall);
    exp_t e;
    @(posedge clk); #1;
    reset          = rst;
    bus.req        = rq;
    bus.mdOp_E     = op;
    bus.md_use_D   = use_d;
    bus.stall_data = sd;
    e.name = nm;
    e.v    = {e_start, e_busy, e_done, e_stall, !e_stall, !e_stall, e_stall, 1'b1};
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; bus.req = 1'b0; bus.mdOp_E = 4'd0; bus.md_use_D = 1'b0; bus.stall_data = 1'b0;
    repeat (2) @(posedge clk);

    // reset state, idle
    step("reset_idle", 0, 0, 4'd0, 0, 0,  0, 0, 0, 0);
    step("idle2",      0, 0, 4'd0, 0, 0,  0, 0, 0, 0);

    // mult: start c0, busy c1-5, done c5, idle c6
    step("mult_start", 0, 0, 4'd1, 0, 0,  1, 0, 0, 0);
    step("mult_busy1", 0, 0, 4'd0, 0, 0,  0, 1, 0, 0);
    step("mult_busy2", 0, 0, 4'd5, 0, 0,  0, 1, 0, 0);
    for (int i = 3; i <= 4; i++)
      step("mult_busy", 0, 0, 4'd0, 0, 0,  0, 1, 0, 0);
    step("mult_done",  0, 0, 4'd0, 0, 0,  0, 1, 1, 0);
    step("mult_idle",  0, 0, 4'd0, 0, 0,  0, 0, 0, 0);

    // div then mfhi in ID: stall c0-10, clear c11
    step("div_start",  0, 0, 4'd3, 1, 0,  1, 0, 0, 1);
    for (int i = 1; i <= 9; i++)
      step("div_stall", 0, 0, 4'd0, 1, 0,  0, 1, 0, 1);
    step("div_done",   0, 0, 4'd0, 1, 0,  0, 1, 1, 1);
    step("div_release",0, 0, 4'd0, 1, 0,  0, 0, 0, 0);

    // multu with req: no launch
    step("req_coll",   0, 1, 4'd2, 1, 0,  0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      step("req_quiet", 0, 0, 4'd0, 0, 0,  0, 0, 0, 0);

    // divu: 10 busy cycles; a stray div while busy is ignored
    step("divu_start", 0, 0, 4'd4, 0, 0,  1, 0, 0, 0);
    step("divu_stray", 0, 0, 4'd3, 0, 0,  0, 1, 0, 0);
    for (int i = 2; i <= 9; i++)
      step("divu_busy", 0, 0, 4'd0, 0, 0,  0, 1, 0, 0);
    step("divu_done",  0, 0, 4'd0, 0, 0,  0, 1, 1, 0);
    step("divu_idle",  0, 0, 4'd0, 0, 0,  0, 0, 0, 0);

    // reset mid-run: div at c0, reset at c3, idle from c4 with no done
    step("rst_div",    0, 0, 4'd3, 0, 0,  1, 0, 0, 0);
    step("rst_busy1",  0, 0, 4'd0, 0, 0,  0, 1, 0, 0);
    step("rst_busy2",  0, 0, 4'd0, 0, 0,  0, 1, 0, 0);
    step("rst_assert", 1, 1, 4'd0, 0, 0,  0, 1, 0, 0);
    for (int i = 0; i < 12; i++)
      step("rst_after", 0, 0, 4'd0, 0, 0,  0, 0, 0, 0);

    // independent data stall, reserved opcodes, MD use without MD work
    step("data_stall", 0, 0, 4'd0, 0, 1,  0, 0, 0, 1);
    step("op9_none",   0, 0, 4'd9, 1, 0,  0, 0, 0, 0);
    step("op15_none",  0, 0, 4'd15,1, 0,  0, 0, 0, 0);
    step("mthi_use",   0, 0, 4'd7, 1, 0,  0, 0, 0, 0);
    step("mult_data",  0, 0, 4'd1, 0, 1,  1, 0, 0, 1);
    step("busy_nomd",  0, 0, 4'd0, 0, 0,  0, 1, 0, 0);
    step("busy_md",    0, 0, 4'd0, 1, 0,  0, 1, 0, 1);

    @(posedge clk); #1;
    reset = 1'b0; bus.md_use_D = 1'b0;
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
